// File: rtl/epd_frame_gen_if.sv
// Byte-stream bus between the frame generator, its payload source and the packet detector.
// The master modport is the upstream/test side; the generator attaches as slave.
interface epd_frame_gen_if;
    logic        start;
    logic [47:0] dst_addr;
    logic [47:0] src_addr;
    logic [15:0] type_length;
    logic [10:0] payload_len;
    logic [7:0]  pld_data;
    logic        pld_valid;
    logic        pld_ready;
    logic [7:0]  data;
    logic        control;
    logic        busy;
    logic        underrun;
    logic [3:0]  frames_sent;

    modport master (
        output start, dst_addr, src_addr, type_length, payload_len, pld_data, pld_valid,
        input  pld_ready, data, control, busy, underrun, frames_sent
    );

    modport slave (
        input  start, dst_addr, src_addr, type_length, payload_len, pld_data, pld_valid,
        output pld_ready, data, control, busy, underrun, frames_sent
    );
endinterface

// File: rtl/epd_frame_gen.sv
// Ethernet frame byte generator: preamble, SFD, addresses, type, payload, pad, inter-frame gap.
// Define EPD_FRAME_GEN_FCS_EN to append a CRC-32 FCS after the payload/pad.
module epd_frame_gen #(
    parameter int IFG_LEN = 1,
    parameter int MIN_PLD = 46
) (
    input logic              clock_i,
    input logic              reset_i,
    epd_frame_gen_if.slave   bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_TYPE, S_PLD, S_PAD, S_FCS, S_IFG
    } state_t;

    localparam logic [10:0] MAX_PLD   = 11'd1500;
    localparam logic [10:0] MIN_PLD_W = 11'(MIN_PLD);
    localparam logic [10:0] IFG_LAST  = 11'(IFG_LEN - 1);

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [47:0] dst_q, dst_d;
    logic [47:0] src_q, src_d;
    logic [15:0] type_q, type_d;
    logic [10:0] len_q, len_d;
    logic [7:0]  data_q, data_d;
    logic        control_q, control_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        underrun_q, underrun_d;
    logic [3:0]  frames_q, frames_d;

    logic        go_accept_s;
    logic        go_pld_s;
    logic        go_tail_s;
    logic        go_end_s;
    logic [10:0] accepted_s;

    function automatic logic [7:0] byte48(input logic [47:0] v, input logic [2:0] idx);
        int sh;
        sh = 40 - 8 * int'(idx);
        return v[sh +: 8];
    endfunction

`ifdef EPD_FRAME_GEN_FCS_EN
    logic [31:0] crc_q, crc_d;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h000000, b};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 32'hEDB88320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
        int sh;
        sh = 8 * int'(idx);
        return ~crc[sh +: 8];
    endfunction
`endif

    // Next-state and next-output selection; data_d/control_d describe the byte shown next cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dst_d       = dst_q;
        src_d       = src_q;
        type_d      = type_q;
        len_d       = len_q;
        data_d      = 8'h00;
        control_d   = 1'b0;
        ready_d     = 1'b0;
        underrun_d  = 1'b0;
        frames_d    = frames_q;
        go_accept_s = 1'b0;
        go_pld_s    = 1'b0;
        go_tail_s   = 1'b0;
        go_end_s    = 1'b0;
        accepted_s  = 11'd0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    go_accept_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                control_d = 1'b1;
                if (cnt_q == 11'd6) begin
                    state_d = S_SFD;
                    cnt_d   = 11'd0;
                    data_d  = 8'hD5;
                end else begin
                    cnt_d  = cnt_q + 11'd1;
                    data_d = 8'h55;
                end
            end
            S_SFD: begin
                state_d   = S_DST;
                cnt_d     = 11'd0;
                data_d    = byte48(dst_q, 3'd0);
                control_d = 1'b1;
            end
            S_DST: begin
                control_d = 1'b1;
                if (cnt_q == 11'd5) begin
                    state_d = S_SRC;
                    cnt_d   = 11'd0;
                    data_d  = byte48(src_q, 3'd0);
                end else begin
                    cnt_d  = cnt_q + 11'd1;
                    data_d = byte48(dst_q, cnt_q[2:0] + 3'd1);
                end
            end
            S_SRC: begin
                control_d = 1'b1;
                if (cnt_q == 11'd5) begin
                    state_d = S_TYPE;
                    cnt_d   = 11'd0;
                    data_d  = type_q[15:8];
                end else begin
                    cnt_d  = cnt_q + 11'd1;
                    data_d = byte48(src_q, cnt_q[2:0] + 3'd1);
                end
            end
            S_TYPE: begin
                if (cnt_q == 11'd0) begin
                    cnt_d     = 11'd1;
                    data_d    = type_q[7:0];
                    control_d = 1'b1;
                    ready_d   = (len_q != 11'd0);
                end else begin
                    accepted_s = 11'd0;
                    go_pld_s   = 1'b1;
                end
            end
            S_PLD: begin
                // cnt_q indexes the payload byte on data, so one more has been accepted
                accepted_s = cnt_q + 11'd1;
                go_pld_s   = 1'b1;
            end
            S_PAD: begin
                if (cnt_q + 11'd1 == MIN_PLD_W - len_q) begin
                    go_end_s = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 11'd1;
                    control_d = 1'b1;
                end
            end
`ifdef EPD_FRAME_GEN_FCS_EN
            S_FCS: begin
                if (cnt_q == 11'd3) begin
                    state_d  = S_IFG;
                    cnt_d    = 11'd0;
                    frames_d = frames_q + 4'd1;
                end else begin
                    cnt_d     = cnt_q + 11'd1;
                    data_d    = fcs_byte(crc_q, cnt_q[1:0] + 2'd1);
                    control_d = 1'b1;
                end
            end
`endif
            S_IFG: begin
                // The final gap cycle samples start so a waiting request follows with no extra idle
                if (cnt_q == IFG_LAST) begin
                    if (bus.start) begin
                        go_accept_s = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 11'd0;
            end
        endcase

        if (go_pld_s) begin
            if (accepted_s < len_q) begin
                if (bus.pld_valid) begin
                    state_d   = S_PLD;
                    cnt_d     = accepted_s;
                    data_d    = bus.pld_data;
                    control_d = 1'b1;
                    ready_d   = (accepted_s + 11'd1 < len_q);
                end else begin
                    state_d    = S_IFG;
                    cnt_d      = 11'd0;
                    underrun_d = 1'b1;
                end
            end else begin
                go_tail_s = 1'b1;
            end
        end else begin
            go_tail_s = 1'b0;
        end

        if (go_tail_s) begin
            if (len_q < MIN_PLD_W) begin
                state_d   = S_PAD;
                cnt_d     = 11'd0;
                data_d    = 8'h00;
                control_d = 1'b1;
            end else begin
                go_end_s = 1'b1;
            end
        end else begin
            go_end_s = go_end_s;
        end

        if (go_end_s) begin
`ifdef EPD_FRAME_GEN_FCS_EN
            state_d   = S_FCS;
            cnt_d     = 11'd0;
            data_d    = fcs_byte(crc_q, 2'd0);
            control_d = 1'b1;
`else
            state_d  = S_IFG;
            cnt_d    = 11'd0;
            frames_d = frames_q + 4'd1;
`endif
        end else begin
            frames_d = frames_d;
        end

        if (go_accept_s) begin
            dst_d     = bus.dst_addr;
            src_d     = bus.src_addr;
            type_d    = bus.type_length;
            len_d     = (bus.payload_len > MAX_PLD) ? MAX_PLD : bus.payload_len;
            state_d   = S_PRE;
            cnt_d     = 11'd0;
            data_d    = 8'h55;
            control_d = 1'b1;
        end else begin
            len_d = len_d;
        end

        busy_d = (state_d != S_IDLE);
    end

`ifdef EPD_FRAME_GEN_FCS_EN
    // CRC accumulates every byte from DST through PAD as it is registered onto data
    always_comb begin
        if (go_accept_s) begin
            crc_d = 32'hFFFFFFFF;
        end else if (state_d inside {S_DST, S_SRC, S_TYPE, S_PLD, S_PAD}) begin
            crc_d = crc32_byte(crc_q, data_d);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC accumulator register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            crc_q <= 32'hFFFFFFFF;
        end else begin
            crc_q <= crc_d;
        end
    end
`endif

    // Frame FSM state, latched header fields and registered outputs
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 11'd0;
            dst_q      <= 48'h0;
            src_q      <= 48'h0;
            type_q     <= 16'h0;
            len_q      <= 11'd0;
            data_q     <= 8'h00;
            control_q  <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            underrun_q <= 1'b0;
            frames_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dst_q      <= dst_d;
            src_q      <= src_d;
            type_q     <= type_d;
            len_q      <= len_d;
            data_q     <= data_d;
            control_q  <= control_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
            frames_q   <= frames_d;
        end
    end

    assign bus.data        = data_q;
    assign bus.control     = control_q;
    assign bus.busy        = busy_q;
    assign bus.pld_ready   = ready_q;
    assign bus.underrun    = underrun_q;
    assign bus.frames_sent = frames_q;

endmodule

// File: tb/tb_epd_frame_gen.sv
// Directed, table-driven bench for epd_frame_gen: frames are captured byte by byte and
// compared with streams the bench builds itself from each record's fields.
module tb_epd_frame_gen;

    localparam int IFG_LEN = 1;
    localparam int MIN_PLD = 46;
`ifdef EPD_FRAME_GEN_FCS_EN
    localparam int FCS_B = 4;
`else
    localparam int FCS_B = 0;
`endif

    typedef struct {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] tl;
        logic [10:0] len;
        logic [7:0]  seed;
        logic [7:0]  step;
        int          under;
        int          exp_len;
        int          exp_rdy;
        int          exp_und;
        int          poke;
    } rec_t;

    localparam int NREC = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    epd_frame_gen_if bus ();

    epd_frame_gen #(.IFG_LEN(IFG_LEN), .MIN_PLD(MIN_PLD)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    rec_t        tbl [NREC];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_frames = 0;

    logic        s_ctl, s_busy, s_rdy, s_und, prev_ctl;
    logic [7:0]  s_data;
    logic [3:0]  s_frames;
    logic [7:0]  cur_seed, cur_step;
    int          cur_under;
    int          acc;
    int          rdy_cnt, und_cnt;
    logic [7:0]  got [$];
    logic [7:0]  expq [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    function automatic logic [7:0] pat(input int idx);
        return 8'(int'(cur_seed) + idx * int'(cur_step));
    endfunction

    // One clock: sample outputs on the falling edge, then drive the payload source
    task automatic cycle();
        @(negedge clk);
        s_ctl = bus.control; s_data = bus.data; s_busy = bus.busy;
        s_rdy = bus.pld_ready; s_und = bus.underrun; s_frames = bus.frames_sent;
        if (s_ctl && !prev_ctl) acc = 0;
        prev_ctl = s_ctl;
        if (s_rdy) rdy_cnt++;
        if (s_und) und_cnt++;
        bus.pld_valid = (acc != cur_under);
        bus.pld_data  = pat(acc);
        if (s_rdy && bus.pld_valid) acc++;
    endtask

    task automatic load(input int i);
        bus.dst_addr    = tbl[i].dst;
        bus.src_addr    = tbl[i].src;
        bus.type_length = tbl[i].tl;
        bus.payload_len = tbl[i].len;
        cur_seed  = tbl[i].seed;
        cur_step  = tbl[i].step;
        cur_under = tbl[i].under;
    endtask

    task automatic build_exp(input int i);
        int n;
        logic [31:0] crc;
        logic [47:0] d, s;
        expq.delete();
        d = tbl[i].dst; s = tbl[i].src;
        for (int k = 0; k < 7; k++) expq.push_back(8'h55);
        expq.push_back(8'hD5);
        for (int k = 5; k >= 0; k--) expq.push_back(d[k*8 +: 8]);
        for (int k = 5; k >= 0; k--) expq.push_back(s[k*8 +: 8]);
        expq.push_back(tbl[i].tl[15:8]);
        expq.push_back(tbl[i].tl[7:0]);
        n = (tbl[i].under >= 0) ? tbl[i].under : ((tbl[i].len > 11'd1500) ? 1500 : int'(tbl[i].len));
        for (int k = 0; k < n; k++) expq.push_back(pat(k));
        if (tbl[i].under < 0) begin
            for (int k = n; k < MIN_PLD; k++) expq.push_back(8'h00);
            if (FCS_B != 0) begin
                crc = 32'hFFFFFFFF;
                for (int k = 8; k < expq.size(); k++) crc = crc_upd(crc, expq[k]);
                crc = ~crc;
                for (int k = 0; k < 4; k++) expq.push_back(crc[k*8 +: 8]);
            end
        end
    endtask

    task automatic run_frame(input int i);
        int g, ifg, idle_bad, mism;
        logic [31:0] res;
        load(i);
        build_exp(i);
        got.delete();
        rdy_cnt = 0; und_cnt = 0;
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        check($sformatf("rec%0d_first_busy", i), {s_busy, s_ctl}, 2'b11);
        g = 0;
        while (s_ctl && g < 4000) begin
            got.push_back(s_data);
            bus.start = (g == tbl[i].poke);
            cycle();
            g++;
        end
        bus.start = 1'b0;
        ifg = 0;
        while (s_busy && ifg < 100) begin
            ifg++;
            cycle();
        end
        if (tbl[i].exp_und == 0) exp_frames = (exp_frames + 1) % 16;
        check($sformatf("rec%0d_ctl_len", i), got.size(),
              tbl[i].exp_len + ((tbl[i].exp_und == 0) ? FCS_B : 0));
        mism = 0;
        for (int k = 0; k < got.size() && k < expq.size(); k++) if (got[k] !== expq[k]) mism++;
        check($sformatf("rec%0d_byte_mismatches", i), mism, 0);
        check($sformatf("rec%0d_ready_cycles", i), rdy_cnt, tbl[i].exp_rdy);
        check($sformatf("rec%0d_underrun_pulses", i), und_cnt, tbl[i].exp_und);
        check($sformatf("rec%0d_ifg_cycles", i), ifg, IFG_LEN);
        check($sformatf("rec%0d_frames_sent", i), s_frames, exp_frames);
        if (FCS_B != 0 && tbl[i].exp_und == 0) begin
            res = 32'hFFFFFFFF;
            for (int k = 8; k < got.size(); k++) res = crc_upd(res, got[k]);
            check($sformatf("rec%0d_crc_residue", i), res, 32'hDEBB20E3);
        end
        idle_bad = 0;
        repeat (4) begin
            cycle();
            if (s_busy || s_ctl) idle_bad++;
        end
        check($sformatf("rec%0d_stays_idle", i), idle_bad, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, falls, low_run, gaps_bad, f15, resumed;
        logic lp;

        tbl[0] = '{48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 11'd46,   8'h55, 8'h00, -1, 68,   46,   0, -1};
        tbl[1] = '{48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 11'd10,   8'h10, 8'h01, -1, 68,   10,   0, 30};
        tbl[2] = '{48'hAABBCCDDEEFF, 48'h112233445566, 16'h0806, 11'd0,    8'h00, 8'h00, -1, 68,   0,    0, -1};
        tbl[3] = '{48'hAABBCCDDEEFF, 48'h112233445566, 16'h86DD, 11'd60,   8'h80, 8'h03, -1, 82,   60,   0, -1};
        tbl[4] = '{48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 11'd46,   8'h20, 8'h01, 29, 51,   30,   1, -1};
        tbl[5] = '{48'h00000000000F, 48'hF00000000000, 16'h05DC, 11'd1600, 8'h00, 8'h01, -1, 1522, 1500, 0, -1};
        tbl[6] = '{48'h123456789ABC, 48'hDEF012345678, 16'h0001, 11'd1,    8'hA5, 8'h00, -1, 68,   1,    0, -1};
        tbl[7] = '{48'h123456789ABC, 48'hDEF012345678, 16'h002F, 11'd47,   8'h01, 8'h07, -1, 69,   47,   0, -1};
        tbl[8] = '{48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 11'd20,   8'h33, 8'h01, 0,  22,   1,    1, -1};
        tbl[9] = '{48'hCAFEBABE0001, 48'h0002DEADBEEF, 16'h0800, 11'd45,   8'h3C, 8'h01, -1, 68,   45,   0, -1};

        bus.start = 1'b0; bus.dst_addr = '0; bus.src_addr = '0; bus.type_length = '0;
        bus.payload_len = '0; bus.pld_data = '0; bus.pld_valid = 1'b0;
        prev_ctl = 1'b0; acc = 0; rdy_cnt = 0; und_cnt = 0;
        load(0);

        rst = 1'b1;
        repeat (3) cycle();
        check("reset_data", s_data, 8'h00);
        check("reset_control", s_ctl, 1'b0);
        check("reset_busy", s_busy, 1'b0);
        check("reset_ready", s_rdy, 1'b0);
        check("reset_underrun", s_und, 1'b0);
        check("reset_frames", s_frames, 4'd0);
        rst = 1'b0;
        cycle();

        // Held start: back-to-back frames, IFG_LEN low cycles between, counter wraps after 16
        load(0);
        bus.start = 1'b1;
        falls = 0; low_run = 0; gaps_bad = 0; f15 = -1; lp = 1'b0; g = 0;
        while (falls < 16 && g < 3000) begin
            cycle();
            g++;
            if (s_ctl && !lp) begin
                if (falls > 0 && low_run != IFG_LEN) gaps_bad++;
                low_run = 0;
            end
            if (!s_ctl) begin
                low_run++;
                if (lp) begin
                    falls++;
                    if (falls == 15) f15 = int'(s_frames);
                end
            end
            lp = s_ctl;
        end
        bus.start = 1'b0;
        check("held_frames_done", falls, 16);
        check("held_gaps_bad", gaps_bad, 0);
        check("held_frames_15", f15, 15);
        check("held_frames_wrap", s_frames, 4'd0);
        g = 0;
        while (s_busy && g < 100) begin cycle(); g++; end
        check("held_busy_falls", s_busy, 1'b0);
        exp_frames = 0;

        for (int i = 0; i < NREC; i++) run_frame(i);

        // Reset in the middle of the payload truncates the frame with no resume
        load(0);
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        repeat (30) cycle();
        check("midrst_in_payload", {s_ctl, s_rdy}, 2'b11);
        rst = 1'b1;
        cycle();
        check("midrst_control", s_ctl, 1'b0);
        check("midrst_data", s_data, 8'h00);
        check("midrst_busy", s_busy, 1'b0);
        check("midrst_frames", s_frames, 4'd0);
        check("midrst_ready", s_rdy, 1'b0);
        rst = 1'b0;
        resumed = 0;
        repeat (5) begin
            cycle();
            if (s_ctl || s_busy) resumed++;
        end
        check("midrst_no_resume", resumed, 0);
        exp_frames = 0;
        run_frame(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
